halt_dump_unit: RTL and testbench

Post-halt state extraction engine that sits directly downstream of `SingleCycleCPU`. Once the CPU asserts `halt`, it walks the register file and then data memory through their combinational read ports. It streams every word out over a valid/ready interface, giving a synthesizable equivalent of the bench's register and memory dumps. The CPU is frozen after `halt`, so the read data is stable for the whole dump.

---
 rtl/halt_dump_unit.sv | 80 ++++++++
 tb/tb_halt_dump_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/halt_dump_unit.sv
// halt_dump_unit: after CPU halt, streams register file then data memory over valid/ready.
//   clk, rst (async active-low), halt            : control
//   rf_addr/rf_data, mem_addr/mem_data           : combinational read ports into the frozen CPU
//   out_valid/out_ready/out_data                 : registered output stream
//   out_is_reg/out_index/out_last                : tags for the word on out_data
//   done                                         : sticky completion flag
module halt_dump_unit #(
  parameter int          NUM_REGS  = 32,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_is_reg,
  output logic [15:0] out_index,
  output logic        out_last,
  output logic        done
);
  localparam logic [31:0] NR    = 32'(NUM_REGS);
  localparam logic [31:0] LAST  = 32'(NUM_REGS + MEM_WORDS - 1);
  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  RUN   = 2'd1;
  localparam logic [1:0]  DRAIN = 2'd2;
  localparam logic [1:0]  DONE  = 2'd3;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic [31:0] mem_idx;
  logic        is_reg;
  logic        load;
  always_comb begin
    is_reg   = cnt < NR;
    mem_idx  = cnt - NR;
    rf_addr  = is_reg ? cnt[4:0] : 5'd0;
    mem_addr = is_reg ? MEM_BASE : MEM_BASE + (mem_idx << 2);
    // a new word may replace the current one only if the slot is empty or being accepted
    load     = (state == RUN) && (!out_valid || out_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_is_reg <= 1'b0;
      out_index  <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (halt) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: if (load) begin
          out_data   <= is_reg ? rf_data : mem_data;
          out_is_reg <= is_reg;
          out_index  <= is_reg ? cnt[15:0] : mem_idx[15:0];
          out_last   <= cnt == LAST;
          out_valid  <= 1'b1;
          cnt        <= cnt + 32'd1;
          if (cnt == LAST) state <= DRAIN;
        end
        DRAIN: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_halt_dump_unit.sv
// tb_halt_dump_unit: randomized self-checking bench for halt_dump_unit against a sequence model.
module tb_halt_dump_unit;
  localparam int          NR    = 32;
  localparam int          MW    = 4;
  localparam int          TOTAL = NR + MW;
  localparam logic [31:0] BASE  = 32'hFFFF_FFFC;
  logic        clk = 0, rst = 0, halt = 0, out_ready = 0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, mem_addr, mem_data, out_data, off;
  logic        out_valid, out_is_reg, out_last, done;
  logic [15:0] out_index;
  logic [31:0] rf [NR];
  logic [31:0] mem [MW];
  int pass_cnt = 0, total_cnt = 0;
  halt_dump_unit #(.NUM_REGS(NR), .MEM_WORDS(MW), .MEM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_reg(out_is_reg), .out_index(out_index), .out_last(out_last), .done(done)
  );
  always #5 clk = ~clk;
  always_comb begin
    rf_data  = rf[rf_addr];
    off      = mem_addr - BASE;
    mem_data = 32'hDEAD_BEEF;
    if (off[1:0] == 2'b00 && off[31:2] < 32'(MW)) mem_data = mem[off[31:2]];
  end
  task automatic fill(input bit spec_values);
    for (int i = 0; i < NR; i++) rf[i] = spec_values ? i * 32'h0101 : $urandom;
    for (int i = 0; i < MW; i++) mem[i] = spec_values ? 32'hA0 + i : $urandom;
  endtask
  task automatic run_dump(input int mode, input string tag);
    int ptr, e, stalls;
    bit fin;
    logic [31:0] ed, ea;
    logic [15:0] ei;
    logic [4:0]  er;
    ptr = 0; e = 0; stalls = 0; fin = 0;
    @(negedge clk); halt = 1; out_ready = 1;
    @(negedge clk); halt = 0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s first_cycle out_valid=%b required 0", tag, out_valid);
    else pass_cnt++;
    while (!fin && e < 10 * TOTAL) begin
      @(negedge clk); e++;
      if (done) begin
        fin = 1;
        total_cnt++;
        if (ptr !== TOTAL || e !== TOTAL + 1 + stalls || out_valid !== 1'b0)
          $display("FAIL %s completion words=%0d cycles=%0d valid=%b required words=%0d cycles=%0d valid=0",
                   tag, ptr, e, out_valid, TOTAL, TOTAL + 1 + stalls);
        else pass_cnt++;
      end else begin
        ed = ptr < NR ? rf[ptr] : (ptr < TOTAL ? mem[ptr - NR] : 32'h0);
        ei = 16'(ptr < NR ? ptr : ptr - NR);
        total_cnt++;
        if (ptr >= TOTAL || {out_valid, out_data, out_is_reg, out_index, out_last} !==
            {1'b1, ed, ptr < NR, ei, ptr == TOTAL - 1})
          $display("FAIL %s word%0d valid=%b data=%h reg=%b idx=%0d last=%b required 1 %h %b %0d %b",
                   tag, ptr, out_valid, out_data, out_is_reg, out_index, out_last,
                   ed, ptr < NR, ei, ptr == TOTAL - 1);
        else pass_cnt++;
        if (ptr + 1 < TOTAL) begin
          er = ptr + 1 < NR ? 5'(ptr + 1) : 5'd0;
          ea = ptr + 1 < NR ? BASE : BASE + 32'(4 * (ptr + 1 - NR));
          total_cnt++;
          if (rf_addr !== er || mem_addr !== ea)
            $display("FAIL %s addr%0d rf_addr=%0d mem_addr=%h required %0d %h", tag, ptr + 1, rf_addr, mem_addr, er, ea);
          else pass_cnt++;
        end
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(e % 2) : 1'($urandom_range(0, 1));
        if (out_valid && out_ready) ptr++;
        else if (out_valid) stalls++;
      end
    end
    if (!fin) begin
      total_cnt++;
      $display("FAIL %s timeout words=%0d required %0d", tag, ptr, TOTAL);
    end
    out_ready = 1;
  endtask
  task automatic test_reset;
    rst = 0;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, out_data, out_is_reg, out_index, out_last, done, rf_addr, mem_addr} !==
        {1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0, BASE})
      $display("FAIL reset outputs valid=%b data=%h done=%b rf_addr=%0d mem_addr=%h required zeros and %h",
               out_valid, out_data, done, rf_addr, mem_addr, BASE);
    else pass_cnt++;
    rst = 1;
  endtask
  task automatic test_idle;
    bit seen = 0;
    halt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid || done) seen = 1;
    end
    total_cnt++;
    if (seen) $display("FAIL idle activity seen=1 required 0");
    else pass_cnt++;
  endtask
  task automatic test_post_done;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      halt = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      total_cnt++;
      if (out_valid !== 1'b0 || done !== 1'b1)
        $display("FAIL post_done cycle%0d valid=%b done=%b required 0 1", i, out_valid, done);
      else pass_cnt++;
    end
    halt = 0;
  endtask
  task automatic test_mid_reset;
    int e = 0;
    fill(0);
    @(negedge clk); halt = 1; out_ready = 1;
    @(negedge clk); halt = 0;
    while (!(out_valid && out_is_reg && out_index == 16'd10) && e < 50) begin
      @(negedge clk); e++;
    end
    out_ready = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    total_cnt++;
    if (e >= 50 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== 32'h0 || rf_addr !== 5'd0 || mem_addr !== BASE)
      $display("FAIL mid_reset async valid=%b done=%b data=%h rf_addr=%0d waited=%0d required 0 0 0 0 <50",
               out_valid, done, out_data, rf_addr, e);
    else pass_cnt++;
    @(negedge clk); rst = 1;
    out_ready = 1;
    fill(1);
    run_dump(0, "restart");
  endtask
  initial begin
    test_reset;
    test_idle;
    fill(1);
    run_dump(0, "basic");
    test_post_done;
    test_reset;
    fill(0);
    run_dump(1, "alternate");
    test_reset;
    fill(0);
    run_dump(2, "random_bp");
    test_reset;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout reached required finish");
    $fatal(1);
  end
endmodule
